// File: rtl/noc_pkg.sv
// Shared NoC router definitions.
// Holds the default flit width and FIFO depth, the output-port index
// enumeration used to combine arbiter grants, and the reset value for
// the one-hot FIFO pointers.
package noc_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int FIFO_DEPTH     = 4;
   localparam int NUM_PORTS      = 5;

   // Index of each local arbiter's grant within a combined grant vector.
   typedef enum logic [2:0] {
      PORT_N = 3'd0,
      PORT_E = 3'd1,
      PORT_W = 3'd2,
      PORT_S = 3'd3,
      PORT_L = 3'd4
   } port_idx_t;

   // One-hot pointer reset value (entry 0). The users slice the low
   // DEPTH bits, so this supports depths up to 32.
   localparam logic [31:0] ONE_HOT_RST = 32'h0000_0001;

endpackage

// File: rtl/rx_flow_ctrl.sv
// Receive-side RTS/DCTS flow control.
// Holds the clear-to-send flop and decides when an upstream flit is
// accepted into the FIFO.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   rts      : upstream request-to-send
//   full     : FIFO full (current occupancy)
//   cts      : registered clear-to-send, drives DCTS
//   write_en : accept the flit on Data_in at the coming edge
module rx_flow_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic rts,
   input  logic full,
   output logic cts,
   output logic write_en
);

   logic cts_ff;

   // Accepting only while cts_ff is low makes DCTS a one-cycle pulse and
   // stops the still-high RTS from being accepted twice for one flit.
   assign write_en = rts & ~cts_ff & ~full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cts_ff <= 1'b0;
      end else begin
         cts_ff <= write_en;
      end
   end

   assign cts = cts_ff;

endmodule

// File: rtl/flit_rx_fifo.sv
// Router input-port receive FIFO.
// Accepts flits over the RTS/DCTS handshake and buffers them in a
// first-word-fall-through FIFO that the five output arbiters drain.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   RTS        : upstream request-to-send
//   Data_in    : upstream flit, valid while RTS=1
//   DCTS       : registered clear-to-send pulse to upstream
//   read_en_*  : grants from the N/E/W/S/L output arbiters
//   Data_out   : head flit, zero read latency
//   empty/full : occupancy flags
//   count      : number of valid entries
module flit_rx_fifo
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     RTS,
   input  logic [DATA_WIDTH-1:0]    Data_in,
   output logic                     DCTS,
   input  logic                     read_en_N,
   input  logic                     read_en_E,
   input  logic                     read_en_W,
   input  logic                     read_en_S,
   input  logic                     read_en_L,
   output logic [DATA_WIDTH-1:0]    Data_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0]      read_ptr;
   logic [DEPTH-1:0]      write_ptr;
   logic [CW-1:0]         count_reg;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] masked [DEPTH];
   logic [NUM_PORTS-1:0]  grant;
   logic                  write_en;
   logic                  read_en;
   logic                  do_read;

   rx_flow_ctrl u_flow_ctrl (
      .clk      (clk),
      .rst      (rst),
      .rts      (RTS),
      .full     (full),
      .cts      (DCTS),
      .write_en (write_en)
   );

   // The arbiters grant at most one output at a time, so an OR suffices.
   assign grant[PORT_N] = read_en_N;
   assign grant[PORT_E] = read_en_E;
   assign grant[PORT_W] = read_en_W;
   assign grant[PORT_S] = read_en_S;
   assign grant[PORT_L] = read_en_L;
   assign read_en       = |grant;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign count   = count_reg;
   assign do_read = read_en & ~empty;

   // Pointers rotate left, MSB wrapping to LSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_ptr  <= ONE_HOT_RST[DEPTH-1:0];
         write_ptr <= ONE_HOT_RST[DEPTH-1:0];
      end else begin
         if (write_en) begin
            write_ptr <= {write_ptr[DEPTH-2:0], write_ptr[DEPTH-1]};
         end
         if (do_read) begin
            read_ptr <= {read_ptr[DEPTH-2:0], read_ptr[DEPTH-1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else begin
         case ({write_en, do_read})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage is intentionally not reset; stale entries are never exposed
   // as valid because empty gates their use.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (write_en && write_ptr[i]) begin
            mem[i] <= Data_in;
         end
      end
   end

   // One-hot read mux: mask every entry by its pointer bit and OR them.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_rd_mask
         assign masked[gi] = mem[gi] & {DATA_WIDTH{read_ptr[gi]}};
      end
   endgenerate

   always_comb begin
      Data_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         Data_out = Data_out | masked[i];
      end
   end

endmodule

// File: tb/tb_flit_rx_fifo.sv
// Self-checking bench for flit_rx_fifo: directed plan followed by random
// upstream/arbiter traffic, checked by a queue-based reference model.
module tb_flit_rx_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          RTS;
   logic [DW-1:0] Data_in;
   logic          DCTS;
   logic          gnt [5];
   logic [DW-1:0] Data_out;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   flit_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .RTS       (RTS),
      .Data_in   (Data_in),
      .DCTS      (DCTS),
      .read_en_N (gnt[0]),
      .read_en_E (gnt[1]),
      .read_en_W (gnt[2]),
      .read_en_S (gnt[3]),
      .read_en_L (gnt[4]),
      .Data_out  (Data_out),
      .empty     (empty),
      .full      (full),
      .count     (count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   // Expected FIFO contents as a plain queue; cts_m is whether a flit was
   // taken at the previous edge (upstream sees the acknowledge now).
   logic [DW-1:0] exp_q [$];
   bit            cts_m = 1'b0;

   always @(negedge clk) begin
      bit rd;
      bit acc;
      int sz;
      if (!rst) begin
         exp_q.delete();
         cts_m = 1'b0;
         chk("rst_dcts",  DCTS,  0);
         chk("rst_empty", empty, 1);
         chk("rst_full",  full,  0);
         chk("rst_count", count, 0);
      end else begin
         sz = exp_q.size();
         chk("dcts",  DCTS,  cts_m);
         chk("count", count, sz);
         chk("empty", empty, sz == 0);
         chk("full",  full,  sz == DEPTH);
         chk("count_le_depth", count <= DEPTH, 1);
         rd  = (gnt[0] | gnt[1] | gnt[2] | gnt[3] | gnt[4]) && sz > 0;
         acc = RTS && !cts_m && sz < DEPTH;
         if (sz > 0) chk("head", Data_out, exp_q[0]);
         if (rd) begin
            void'(exp_q.pop_front());
         end
         if (acc) exp_q.push_back(Data_in);
         cts_m = acc;
         $display("cyc t=%0t rts=%0b din=%08h rd=%0b acc=%0b cnt=%0d dout=%08h",
                  $time, RTS, Data_in, rd, acc, count, Data_out);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_gnt();
      for (int i = 0; i < 5; i++) gnt[i] = 1'b0;
   endtask

   // Raise RTS with a flit and hold it until DCTS is seen.
   task automatic send(input logic [DW-1:0] d);
      bit seen = 1'b0;
      RTS     = 1'b1;
      Data_in = d;
      for (int k = 0; k < 20 && !seen; k++) begin
         cyc();
         if (DCTS) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got DCTS=0 expected DCTS=1 for flit %08h", d);
      end
      RTS = 1'b0;
   endtask

   task automatic drain();
      gnt[4] = 1'b1;
      for (int k = 0; k < 2 * DEPTH && !empty; k++) cyc();
      clr_gnt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      RTS = 1'b0;
      Data_in = '0;
      clr_gnt();
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();

      // 1: single flit, DCTS pulse, fall-through
      RTS = 1'b1; Data_in = 32'hA5A5_0001;
      cyc();
      chk("t1_dcts_c1", DCTS, 1);
      chk("t1_count",   count, 1);
      chk("t1_empty",   empty, 0);
      chk("t1_dout",    Data_out, 32'hA5A5_0001);
      RTS = 1'b0;
      cyc();
      chk("t1_dcts_c2", DCTS, 0);
      drain();

      // 2: fill with 0x10..0x13, hold RTS while full
      for (int i = 0; i < 4; i++) send(32'h10 + i);
      RTS = 1'b1; Data_in = 32'h14;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t2_full",  full, 1);
         chk("t2_count", count, 4);
         chk("t2_dcts",  DCTS, 0);
      end

      // 3: one read from full lets the fifth flit in a cycle later
      chk("t3_dout_pre", Data_out, 32'h10);
      gnt[1] = 1'b1;
      cyc();
      clr_gnt();
      chk("t3_dout_post", Data_out, 32'h11);
      chk("t3_count",     count, 3);
      chk("t3_dcts0",     DCTS, 0);
      cyc();
      chk("t3_dcts1",     DCTS, 1);
      chk("t3_count4",    count, 4);
      RTS = 1'b0;
      cyc();
      drain();

      // 4: simultaneous write and read on a one-entry FIFO
      send(32'h1F);
      cyc();
      RTS = 1'b1; Data_in = 32'h20; gnt[4] = 1'b1;
      cyc();
      RTS = 1'b0; clr_gnt();
      chk("t4_count", count, 1);
      chk("t4_dout",  Data_out, 32'h20);
      drain();

      // 5: read on empty, then wrap with 9 write/read pairs
      gnt[0] = 1'b1;
      cyc();
      clr_gnt();
      chk("t5_count", count, 0);
      chk("t5_empty", empty, 1);
      for (int i = 0; i < 9; i++) begin
         send(i);
         chk("t5_wrap_dout", Data_out, i);
         gnt[3] = 1'b1;
         cyc();
         clr_gnt();
      end

      // 6: asynchronous reset mid-cycle while DCTS=1 and count=2
      send(32'hB0);
      cyc();
      RTS = 1'b1; Data_in = 32'hB1;
      cyc();
      chk("t6_pre_dcts",  DCTS, 1);
      chk("t6_pre_count", count, 2);
      #1 rst = 1'b0;
      #1;
      chk("t6_async_dcts",  DCTS, 0);
      chk("t6_async_count", count, 0);
      chk("t6_async_empty", empty, 1);
      RTS = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      send(32'hC0);
      chk("t6_after_count", count, 1);
      chk("t6_after_dout",  Data_out, 32'hC0);
      drain();

      // Random traffic with varying read pressure
      for (int blk = 0; blk < 15; blk++) begin
         int rdpct;
         rdpct = $urandom_range(5, 90);
         for (int c = 0; c < 100; c++) begin
            cyc();
            clr_gnt();
            if (RTS && DCTS) begin
               RTS = 1'($urandom_range(0, 1));
               Data_in = $urandom;
            end else if (!RTS && $urandom_range(0, 1) == 1) begin
               RTS = 1'b1;
               Data_in = $urandom;
            end
            if ($urandom_range(0, 99) < rdpct) gnt[$urandom_range(0, 4)] = 1'b1;
         end
      end
      RTS = 1'b0;
      clr_gnt();
      cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
